// File: rtl/demux_stream_pkg.sv
// Shared constants and helpers for the demux_stream slice.
// Default geometry, delivered-beat counter width and a popcount helper
// used to sum per-lane drains into the delivery counter.
package demux_stream_pkg;

   localparam int DW_DEFAULT   = 8;
   localparam int NOUT_DEFAULT = 4;
   localparam int CNTW         = 16;
   localparam int MAX_LANES    = 16;

   // Number of set bits in a lane mask (up to MAX_LANES lanes).
   function automatic logic [4:0] popcount16(input logic [MAX_LANES-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/demux_stream_slot.sv
// One-entry output buffer for a single demux lane.
// Latency: beat visible on o_valid/o_data from the edge it loads.
// Backpressure: holds the beat until i_ready; a load in the drain cycle replaces it.
module demux_stream_slot #(
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic [DW-1:0] i_data,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   output logic          o_drain
);

   assign o_drain = o_valid & i_ready;

   // Load wins over drain so a back-to-back beat keeps the lane full; a bare drain leaves data untouched.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_data  <= i_data;
      end else if (o_drain) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_stream.sv
// 1:NOUT registered stream demultiplexer, routing each beat to lane i_sel.
// Latency: one edge from accept to o_valid on the chosen lane.
// Backpressure: o_ready drops only when the addressed lane is full and its consumer is stalled.
module demux_stream
   import demux_stream_pkg::*;
#(
   parameter  int DW   = DW_DEFAULT,
   parameter  int NOUT = NOUT_DEFAULT,
   localparam int SW   = $clog2(NOUT)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SW-1:0]        i_sel,
   input  logic [DW-1:0]        i_data,
   output logic [NOUT-1:0]      o_valid,
   input  logic [NOUT-1:0]      i_ready,
   output logic [NOUT*DW-1:0]   o_data,
   output logic                 o_err,
   output logic [CNTW-1:0]      o_cnt
);

   // Select space is padded to a power of two so indexing by i_sel never runs off the lane vectors.
   localparam int NPAD = 1 << SW;
   localparam logic [SW:0] NOUT_W = (SW+1)'(NOUT);

   logic [NPAD-1:0] vld_pad;
   logic [NPAD-1:0] rdy_pad;
   logic [NOUT-1:0] load;
   logic [NOUT-1:0] drain;
   logic            illegal;
   logic            accept;

   assign vld_pad = NPAD'(o_valid);
   assign rdy_pad = NPAD'(i_ready);

   // Out-of-range selects can only occur for non-power-of-two NOUT; such beats are swallowed.
   assign illegal = ({1'b0, i_sel} >= NOUT_W);
   assign o_ready = illegal | ~vld_pad[i_sel] | rdy_pad[i_sel];
   assign accept  = i_valid & o_ready;

   for (genvar k = 0; k < NOUT; k++) begin : g_lane
      assign load[k] = accept & ~illegal & (i_sel == SW'(k));

      demux_stream_slot #(.DW(DW)) u_slot (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_load  (load[k]),
         .i_data  (i_data),
         .i_ready (i_ready[k]),
         .o_valid (o_valid[k]),
         .o_data  (o_data[k*DW +: DW]),
         .o_drain (drain[k])
      );
   end

   // Error pulse for a dropped beat and running total of beats handed to consumers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_err <= 1'b0;
         o_cnt <= '0;
      end else begin
         o_err <= accept & illegal;
         o_cnt <= o_cnt + CNTW'(popcount16(MAX_LANES'(drain)));
      end
   end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: 4-lane main instance plus a 3-lane
// instance for the illegal-select case. Lane data is checked by a per-lane
// scoreboard popped when a beat drains; control behaviour is checked inline.
module tb_demux_stream;

   localparam int DW   = 8;
   localparam int NOUT = 4;
   localparam int SW   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                valid;
   logic [SW-1:0]       sel;
   logic [DW-1:0]       data;
   logic [NOUT-1:0]     rdy;
   logic                ordy;
   logic [NOUT-1:0]     ovld;
   logic [NOUT*DW-1:0]  odat;
   logic                oerr;
   logic [15:0]         ocnt;

   logic                valid3;
   logic [1:0]          sel3;
   logic [DW-1:0]       data3;
   logic [2:0]          rdy3;
   logic                ordy3;
   logic [2:0]          ovld3;
   logic [3*DW-1:0]     odat3;
   logic                oerr3;
   logic [15:0]         ocnt3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] exp_q [NOUT][$];
   logic [15:0]   exp_cnt;

   demux_stream #(.DW(DW), .NOUT(NOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy), .i_sel(sel),
      .i_data(data), .o_valid(ovld), .i_ready(rdy), .o_data(odat),
      .o_err(oerr), .o_cnt(ocnt)
   );

   demux_stream #(.DW(DW), .NOUT(3)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid3), .o_ready(ordy3), .i_sel(sel3),
      .i_data(data3), .o_valid(ovld3), .i_ready(rdy3), .o_data(odat3),
      .o_err(oerr3), .o_cnt(ocnt3)
   );

   // Scoreboard: a lane that is valid and ready at the falling edge drains on the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NOUT; k++) begin
            if (ovld[k] && rdy[k]) begin
               n_tests++;
               if (exp_q[k].size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected lane %0d got %h want none", k, odat[k*DW +: DW]);
               end else begin
                  logic [DW-1:0] e;
                  e = exp_q[k].pop_front();
                  if (odat[k*DW +: DW] !== e) begin
                     n_fail++;
                     $display("FAIL sb_data lane %0d got %h want %h", k, odat[k*DW +: DW], e);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      for (int k = 0; k < NOUT; k++) exp_q[k].delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; sel = 2'd0; data = 8'h77; rdy = '0;
      #1;
      n_tests++;
      if (ordy !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ordy); end
      tick(); tick();
      rst = 1'b0; valid = 1'b0;
      n_tests++;
      if (ovld !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", ovld); end
      n_tests++;
      if (ocnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", ocnt); end
      n_tests++;
      if (oerr !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", oerr); end
      tick();
      n_tests++;
      if (ovld !== 4'b0000) begin n_fail++; $display("FAIL reset_noload got %b want 0000", ovld); end
      exp_cnt = 16'h0000;
   endtask

   task automatic test_streaming();
      rdy = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] d;
         d = 8'h10 + 8'(i);
         valid = 1'b1; sel = SW'(i); data = d;
         #1;
         n_tests++;
         if (ordy !== 1'b1) begin n_fail++; $display("FAIL stream_ready beat %0d got %b want 1", i, ordy); end
         exp_q[i].push_back(d);
         tick();
         n_tests++;
         if (ovld !== 4'(1 << i)) begin n_fail++; $display("FAIL stream_valid beat %0d got %b want %b", i, ovld, 4'(1 << i)); end
      end
      valid = 1'b0;
      tick();
      exp_cnt = exp_cnt + 16'd4;
      n_tests++;
      if (ovld !== 4'b0000) begin n_fail++; $display("FAIL stream_idle got %b want 0000", ovld); end
      n_tests++;
      if (ocnt !== exp_cnt) begin n_fail++; $display("FAIL stream_cnt got %h want %h", ocnt, exp_cnt); end
   endtask

   task automatic test_back_pressure();
      rdy = 4'b1011;
      valid = 1'b1; sel = 2'd2; data = 8'hA5;
      #1;
      n_tests++;
      if (ordy !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got %b want 1", ordy); end
      exp_q[2].push_back(8'hA5);
      tick();
      data = 8'h5A;
      #1;
      n_tests++;
      if (ordy !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got %b want 0", ordy); end
      tick(); tick();
      n_tests++;
      if (odat[2*DW +: DW] !== 8'hA5) begin n_fail++; $display("FAIL bp_hold_data got %h want a5", odat[2*DW +: DW]); end
      n_tests++;
      if (ovld !== 4'b0100) begin n_fail++; $display("FAIL bp_hold_valid got %b want 0100", ovld); end
      rdy = 4'b1111;
      #1;
      n_tests++;
      if (ordy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", ordy); end
      exp_q[2].push_back(8'h5A);
      tick();
      valid = 1'b0; rdy = 4'b1011;
      n_tests++;
      if (odat[2*DW +: DW] !== 8'h5A || ovld[2] !== 1'b1) begin
         n_fail++; $display("FAIL bp_same_edge got %h/%b want 5a/1", odat[2*DW +: DW], ovld[2]);
      end
      exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic test_lane_independence();
      rdy = 4'b0000;
      valid = 1'b1; sel = 2'd1; data = 8'h33;
      #1;
      n_tests++;
      if (ordy !== 1'b1) begin n_fail++; $display("FAIL indep_ready got %b want 1", ordy); end
      exp_q[1].push_back(8'h33);
      tick();
      valid = 1'b0;
      n_tests++;
      if (ovld !== 4'b0110) begin n_fail++; $display("FAIL indep_valid got %b want 0110", ovld); end
      n_tests++;
      if (odat[1*DW +: DW] !== 8'h33) begin n_fail++; $display("FAIL indep_data got %h want 33", odat[1*DW +: DW]); end
      rdy = 4'b1111;
      tick(); tick();
      exp_cnt = exp_cnt + 16'd2;
      n_tests++;
      if (ovld !== 4'b0000) begin n_fail++; $display("FAIL indep_drain got %b want 0000", ovld); end
      n_tests++;
      if (ocnt !== exp_cnt) begin n_fail++; $display("FAIL indep_cnt got %h want %h", ocnt, exp_cnt); end
   endtask

   task automatic test_illegal_select();
      rdy3 = 3'b000;
      valid3 = 1'b1; sel3 = 2'd0; data3 = 8'h42;
      tick();
      sel3 = 2'd3; data3 = 8'hFF;
      #1;
      n_tests++;
      if (ordy3 !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %b want 1", ordy3); end
      tick();
      valid3 = 1'b0;
      n_tests++;
      if (oerr3 !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", oerr3); end
      n_tests++;
      if (ovld3 !== 3'b001) begin n_fail++; $display("FAIL illegal_valid got %b want 001", ovld3); end
      n_tests++;
      if (odat3[0 +: DW] !== 8'h42) begin n_fail++; $display("FAIL illegal_data got %h want 42", odat3[0 +: DW]); end
      n_tests++;
      if (ocnt3 !== 16'h0000) begin n_fail++; $display("FAIL illegal_cnt got %h want 0000", ocnt3); end
      tick();
      n_tests++;
      if (oerr3 !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got %b want 0", oerr3); end
      rdy3 = 3'b111;
      tick();
      n_tests++;
      if (ocnt3 !== 16'h0001) begin n_fail++; $display("FAIL illegal_drain_cnt got %h want 0001", ocnt3); end
   endtask

   task automatic test_wrap_and_reset();
      rst = 1'b1; valid = 1'b0; rdy = 4'b1111;
      tick();
      rst = 1'b0;
      clear_sb();
      exp_cnt = 16'h0000;
      for (int i = 0; i < 32'hFFFE; i++) begin
         valid = 1'b1; sel = i[1:0]; data = i[7:0];
         exp_q[i % 4].push_back(i[7:0]);
         tick();
      end
      valid = 1'b0;
      tick();
      exp_cnt = 16'hFFFE;
      n_tests++;
      if (ocnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_preload got %h want %h", ocnt, exp_cnt); end
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; sel = SW'(i); data = 8'hC0 + 8'(i);
         exp_q[i].push_back(8'hC0 + 8'(i));
         tick();
      end
      valid = 1'b0;
      tick();
      exp_cnt = exp_cnt + 16'd3;
      n_tests++;
      if (ocnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt got %h want %h", ocnt, exp_cnt); end
      n_tests++;
      if (exp_cnt !== 16'h0001 || ocnt !== 16'h0001) begin n_fail++; $display("FAIL wrap_value got %h want 0001", ocnt); end
      rdy = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; sel = SW'(i); data = 8'hE0 + 8'(i);
         tick();
      end
      valid = 1'b0;
      n_tests++;
      if (ovld !== 4'b1111) begin n_fail++; $display("FAIL full_valid got %b want 1111", ovld); end
      rst = 1'b1;
      tick();
      n_tests++;
      if (ovld !== 4'b0000) begin n_fail++; $display("FAIL midop_reset_valid got %b want 0000", ovld); end
      n_tests++;
      if (ocnt !== 16'h0000) begin n_fail++; $display("FAIL midop_reset_cnt got %h want 0000", ocnt); end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; sel = '0; data = '0; rdy = '0;
      valid3 = 1'b0; sel3 = '0; data3 = '0; rdy3 = '0;
      exp_cnt = '0;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_lane_independence();
      for (int k = 0; k < NOUT; k++) begin
         n_tests++;
         if (exp_q[k].size() != 0) begin n_fail++; $display("FAIL sb_leftover lane %0d got %0d want 0", k, exp_q[k].size()); end
      end
      test_illegal_select();
      test_wrap_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
